// File: rtl/el_counter_ctrl.sv
// el_counter_ctrl: clocked sequencer and handshake partner for the self-timed dual-rail el_counter.
// Defining EL_CTRL_SEQ_CHECK_EN adds the prev+1 sequence check (error code 11).
module el_counter_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_i,
    input  logic [15:0]        num_i,
    output logic               start_o,
    output logic               ack_i_o,
    input  logic               ack_o_i,
    input  logic [2*WIDTH-1:0] dr_i,
    output logic [WIDTH-1:0]   cnt_o,
    output logic               cnt_valid_o,
    input  logic               cnt_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [1:0]         err_code_o
);
    localparam int            TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_SETTLE, S_HOLD, S_DONE, S_ERR
    } state_t;

    state_t r_state, w_next;

    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [2*WIDTH-1:0]     r_dr_sync [SYNC_STAGES];
    logic [2*WIDTH-1:0]     r_dr_prev;
    logic [2*WIDTH-1:0]     w_dr;

    logic                   r_run_q;
    logic                   r_start;
    logic                   r_ack_i;
    logic                   r_err;
    logic [1:0]             r_err_code;
    logic [15:0]            r_remaining;
    logic                   r_cont;
    logic [TW-1:0]          r_timer;
    logic [1:0]             r_stable;
    logic [WIDTH-1:0]       r_cnt;

    logic                   w_pending;
    logic [WIDTH-1:0]       w_dec;
    logic                   w_complete;
    logic                   w_illegal;
    logic                   w_stable_eq;
    logic                   w_timeout;
    logic                   w_seq_ok;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_launch;
    logic                   w_fail;
    logic [1:0]             w_fail_code;
    logic                   w_deliver;

    function automatic logic [WIDTH-1:0] dr_value(input logic [2*WIDTH-1:0] dr);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < WIDTH; k++) v[k] = dr[2*k+1];
        return v;
    endfunction

    function automatic logic dr_complete(input logic [2*WIDTH-1:0] dr);
        logic c;
        c = 1'b1;
        for (int k = 0; k < WIDTH; k++) if (dr[2*k+1] == dr[2*k]) c = 1'b0;
        return c;
    endfunction

    function automatic logic dr_illegal(input logic [2*WIDTH-1:0] dr);
        logic x;
        x = 1'b0;
        for (int k = 0; k < WIDTH; k++) if (dr[2*k+1] & dr[2*k]) x = 1'b1;
        return x;
    endfunction

    // Async inputs: ack and every dual-rail bit through SYNC_STAGES flops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_dr_sync[i] <= '0;
            r_dr_prev <= '0;
        end else begin
            r_ack_sync   <= {r_ack_sync[SYNC_STAGES-2:0], ack_o_i};
            r_dr_sync[0] <= dr_i;
            for (int i = 1; i < SYNC_STAGES; i++) r_dr_sync[i] <= r_dr_sync[i-1];
            r_dr_prev <= w_dr;
        end
    end

    assign w_dr        = r_dr_sync[SYNC_STAGES-1];
    assign w_pending   = r_ack_sync[SYNC_STAGES-1] ^ r_ack_i;
    assign w_dec       = dr_value(w_dr);
    assign w_complete  = dr_complete(w_dr);
    assign w_illegal   = dr_illegal(w_dr);
    assign w_stable_eq = (w_dr == r_dr_prev) && w_complete;
    assign w_timeout   = (r_timer == TMAX);
    assign w_accept    = (r_state == S_HOLD) && cnt_ready_i;
    assign w_last      = r_cont ? !run_i : (r_remaining == 16'd1);

`ifdef EL_CTRL_SEQ_CHECK_EN
    logic [WIDTH-1:0] r_ref;
    logic             r_have_ref;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref      <= '0;
            r_have_ref <= 1'b0;
        end else if (w_launch) begin
            r_have_ref <= 1'b0;
        end else if (w_deliver) begin
            r_ref      <= w_dec;
            r_have_ref <= 1'b1;
        end
    end

    assign w_seq_ok = !r_have_ref || (w_dec == r_ref + WIDTH'(1));
`else
    assign w_seq_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_launch    = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = 2'b00;
        w_deliver   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run_i && !r_run_q) begin
                    w_launch = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_timeout) begin
                    w_fail      = 1'b1;
                    w_fail_code = 2'b01;
                end else if (w_pending) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_illegal) begin
                    w_fail      = 1'b1;
                    w_fail_code = 2'b10;
                end else if (w_timeout) begin
                    w_fail      = 1'b1;
                    w_fail_code = 2'b01;
                end else if (w_stable_eq && r_stable == 2'd1) begin
                    // Second consecutive stable compare: the word is trusted
                    if (w_seq_ok) begin
                        w_deliver = 1'b1;
                        w_next    = S_HOLD;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = 2'b11;
                    end
                end
            end
            S_HOLD: begin
                if (w_accept) w_next = w_last ? S_DONE : S_WAIT;
            end
            S_DONE: w_next = S_IDLE;
            S_ERR: begin
                if (!run_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_fail) w_next = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_q     <= 1'b0;
            r_start     <= 1'b0;
            r_ack_i     <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
            r_remaining <= '0;
            r_cont      <= 1'b0;
            r_timer     <= '0;
            r_stable    <= '0;
            r_cnt       <= '0;
        end else begin
            r_run_q <= run_i;
            if (w_launch) begin
                r_start     <= ~r_start;
                r_remaining <= num_i;
                r_cont      <= (num_i == 16'd0);
                r_err       <= 1'b0;
                r_err_code  <= 2'b00;
            end
            if (w_fail) begin
                r_err      <= 1'b1;
                r_err_code <= w_fail_code;
            end
            if (w_accept) begin
                r_ack_i <= ~r_ack_i;
                if (!r_cont) r_remaining <= r_remaining - 16'd1;
            end
            // Timer runs only while waiting for a word; parked at zero elsewhere
            if (r_state == S_WAIT || r_state == S_SETTLE) begin
                if (r_timer != TMAX) r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= '0;
            end
            if (r_state == S_SETTLE && w_stable_eq) begin
                if (r_stable != 2'd3) r_stable <= r_stable + 2'd1;
            end else begin
                r_stable <= '0;
            end
            if (w_deliver) r_cnt <= w_dec;
        end
    end

    assign start_o     = r_start;
    assign ack_i_o     = r_ack_i;
    assign cnt_o       = r_cnt;
    assign cnt_valid_o = (r_state == S_HOLD);
    assign busy_o      = (r_state == S_WAIT) || (r_state == S_SETTLE) ||
                         (r_state == S_HOLD) || (r_state == S_DONE);
    assign done_o      = (r_state == S_DONE);
    assign err_o       = r_err;
    assign err_code_o  = r_err_code;
endmodule

// File: tb/tb_el_counter_ctrl.sv
// Directed bench for el_counter_ctrl: single-sample vector table plus multi-cycle session sequences.
module tb_el_counter_ctrl;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           run_i = 1'b0;
    logic [15:0]    num_i = '0;
    logic           start_o;
    logic           ack_i_o;
    logic           ack_o_i = 1'b0;
    logic [2*W-1:0] dr_i = '0;
    logic [W-1:0]   cnt_o;
    logic           cnt_valid_o;
    logic           cnt_ready_i = 1'b1;
    logic           busy_o;
    logic           done_o;
    logic           err_o;
    logic [1:0]     err_code_o;

    el_counter_ctrl #(.WIDTH(W), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .run_i(run_i), .num_i(num_i),
        .start_o(start_o), .ack_i_o(ack_i_o), .ack_o_i(ack_o_i), .dr_i(dr_i),
        .cnt_o(cnt_o), .cnt_valid_o(cnt_valid_o), .cnt_ready_i(cnt_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp;
    int n_bad;

    // Event counters sampled on the falling edge, away from the active edge
    int       n_ack;
    int       n_start;
    int       n_done;
    int       n_beat;
    bit       m_ack;
    bit       m_start;
    logic [W-1:0] beat_val [16];
    always @(negedge clk) begin
        if (ack_i_o != m_ack) n_ack++;
        if (start_o != m_start) n_start++;
        m_ack   = ack_i_o;
        m_start = start_o;
        if (done_o) n_done++;
        if (cnt_valid_o && cnt_ready_i) begin
            beat_val[n_beat % 16] = cnt_o;
            n_beat++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2*W-1:0] dr;
        logic           exp_err;
        logic [1:0]     exp_code;
        logic [W-1:0]   exp_cnt;
    } vec_t;
    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] enc(input logic [W-1:0] v);
        logic [2*W-1:0] r;
        r = '0;
        for (int k = 0; k < W; k++) r[2*k +: 2] = v[k] ? 2'b10 : 2'b01;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1; run_i = 1'b0; ack_o_i = 1'b0; dr_i = '0; cnt_ready_i = 1'b1; num_i = '0;
        repeat (4) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_start_o"},    32'(start_o), 0);
        check({tag, "_ack_i_o"},    32'(ack_i_o), 0);
        check({tag, "_cnt_o"},      32'(cnt_o), 0);
        check({tag, "_cnt_valid"},  32'(cnt_valid_o), 0);
        check({tag, "_busy_o"},     32'(busy_o), 0);
        check({tag, "_done_o"},     32'(done_o), 0);
        check({tag, "_err_o"},      32'(err_o), 0);
        check({tag, "_err_code_o"}, 32'(err_code_o), 0);
    endtask

    task automatic start_session(input logic [15:0] n);
        logic e;
        e = ~start_o;
        num_i = n;
        run_i = 1'b1;
        tick();
        check("start_toggle", 32'(start_o), 32'(e));
    endtask

    // Counter model: present a word, let it settle, then toggle ack_o_i
    task automatic deliver(input logic [2*W-1:0] w, input logic exp_err, input logic [1:0] exp_code,
                           input logic [W-1:0] exp_val, input bit auto_ack, output int lat);
        logic pa;
        int   t0;
        dr_i = w;
        repeat (3) tick();
        ack_o_i = ~ack_o_i;
        t0 = cyc;
        for (int i = 0; i < TO + 20 && !(cnt_valid_o || err_o); i++) tick();
        lat = cyc - t0;
        if (exp_err) begin
            check("err_o", 32'(err_o), 1);
            check("err_code", 32'(err_code_o), 32'(exp_code));
            check("no_valid", 32'(cnt_valid_o), 0);
        end else begin
            check("cnt_valid", 32'(cnt_valid_o), 1);
            check("cnt_value", 32'(cnt_o), 32'(exp_val));
            if (auto_ack) begin
                pa = ack_i_o;
                for (int i = 0; i < 10 && ack_i_o == pa; i++) tick();
                check("ack_toggle", 32'(ack_i_o != pa), 1);
            end
        end
    endtask

    int   lat;
    int   b_ack, b_start, b_done, b_beat;
    int   t0;
    logic pa;
    logic [W-1:0] c;
    bit   ok;

    initial begin
        vecs[0] = '{16'h5555, 1'b0, 2'b00, 8'h00};
        vecs[1] = '{16'hAAAA, 1'b0, 2'b00, 8'hFF};
        vecs[2] = '{16'h9966, 1'b0, 2'b00, 8'hA5};
        vecs[3] = '{16'h5AA5, 1'b0, 2'b00, 8'h3C};
        vecs[4] = '{16'h5D55, 1'b1, 2'b10, 8'h00};
        vecs[5] = '{16'h5557, 1'b1, 2'b10, 8'h00};
        vecs[6] = '{16'h5554, 1'b1, 2'b01, 8'h00};

        do_reset();
        check_reset_vals("reset");

        // Ten-sample session, counter 0..9, consumer always ready
        b_ack = n_ack; b_start = n_start; b_done = n_done; b_beat = n_beat;
        start_session(16'd10);
        for (int v = 0; v < 10; v++) begin
            deliver(enc(W'(v)), 1'b0, 2'b00, W'(v), 1'b1, lat);
            if (v == 0) check("first_latency", 32'(lat), 32'(S + 3));
        end
        tick(); tick();
        check("main_beats", 32'(n_beat - b_beat), 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("main_beat%0d", i), 32'(beat_val[(b_beat + i) % 16]), 32'(i));
        check("main_ack_toggles", 32'(n_ack - b_ack), 10);
        check("main_start_toggles", 32'(n_start - b_start), 1);
        check("main_done_pulses", 32'(n_done - b_done), 1);
        check("main_busy_after", 32'(busy_o), 0);
        run_i = 1'b0;
        tick();

        // Single-sample table
        for (int i = 0; i < 7; i++) begin
            do_reset();
            b_done = n_done;
            start_session(16'd1);
            deliver(vecs[i].dr, vecs[i].exp_err, vecs[i].exp_code, vecs[i].exp_cnt, 1'b1, lat);
            if (!vecs[i].exp_err) begin
                tick(); tick();
                check($sformatf("vec%0d_done", i), 32'(n_done - b_done), 1);
            end
            run_i = 1'b0;
            tick();
        end

        // Stall after sample 3: timeout exactly TO cycles after WAIT entry
        do_reset();
        start_session(16'd10);
        for (int v = 0; v < 4; v++) deliver(enc(W'(v)), 1'b0, 2'b00, W'(v), 1'b1, lat);
        t0 = cyc;
        pa = ack_i_o;
        for (int i = 0; i < TO + 20 && !err_o; i++) tick();
        check("timeout_latency", 32'(cyc - t0), 32'(TO));
        check("timeout_err", 32'(err_o), 1);
        check("timeout_code", 32'(err_code_o), 1);
        check("timeout_busy", 32'(busy_o), 0);
        repeat (5) tick();
        check("timeout_no_ack", 32'(ack_i_o), 32'(pa));
        run_i = 1'b0;
        tick();

        // Consumer back-pressure for 20 cycles in HOLD
        do_reset();
        b_done = n_done;
        start_session(16'd2);
        cnt_ready_i = 1'b0;
        deliver(enc(8'd7), 1'b0, 2'b00, 8'd7, 1'b0, lat);
        c  = cnt_o;
        pa = ack_i_o;
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (cnt_o !== c || cnt_valid_o !== 1'b1 || err_o !== 1'b0 || ack_i_o !== pa) ok = 1'b0;
        end
        check("stall_hold_stable", 32'(ok), 1);
        b_ack = n_ack;
        cnt_ready_i = 1'b1;
        tick(); tick();
        check("stall_one_ack", 32'(n_ack - b_ack), 1);
        check("stall_valid_drop", 32'(cnt_valid_o), 0);
        deliver(enc(8'd8), 1'b0, 2'b00, 8'd8, 1'b1, lat);
        tick(); tick();
        check("stall_done", 32'(n_done - b_done), 1);
        run_i = 1'b0;
        tick();

        // Wrap 254,255,0 then a skip to 2
        do_reset();
        b_done = n_done;
        start_session(16'd4);
        deliver(enc(8'd254), 1'b0, 2'b00, 8'd254, 1'b1, lat);
        deliver(enc(8'd255), 1'b0, 2'b00, 8'd255, 1'b1, lat);
        deliver(enc(8'd0),   1'b0, 2'b00, 8'd0,   1'b1, lat);
`ifdef EL_CTRL_SEQ_CHECK_EN
        deliver(enc(8'd2), 1'b1, 2'b11, 8'd0, 1'b1, lat);
`else
        deliver(enc(8'd2), 1'b0, 2'b00, 8'd2, 1'b1, lat);
        tick(); tick();
        check("seq_done", 32'(n_done - b_done), 1);
`endif
        run_i = 1'b0;
        tick();

        // Continuous session ends when run_i drops during HOLD
        do_reset();
        b_done = n_done; b_beat = n_beat;
        start_session(16'd0);
        for (int v = 0; v < 4; v++) deliver(enc(W'(20 + v)), 1'b0, 2'b00, W'(20 + v), 1'b1, lat);
        cnt_ready_i = 1'b0;
        deliver(enc(8'd24), 1'b0, 2'b00, 8'd24, 1'b0, lat);
        run_i = 1'b0;
        cnt_ready_i = 1'b1;
        tick(); tick(); tick();
        check("cont_done", 32'(n_done - b_done), 1);
        check("cont_beats", 32'(n_beat - b_beat), 5);
        check("cont_busy_after", 32'(busy_o), 0);

        // Second session, reset asserted mid-SETTLE
        start_session(16'd0);
        dr_i = enc(8'd55);
        repeat (3) tick();
        ack_o_i = ~ack_o_i;
        repeat (3) tick();
        check("pre_rst_busy", 32'(busy_o), 1);
        check("pre_rst_valid", 32'(cnt_valid_o), 0);
        rst = 1'b1;
        tick();
        check_reset_vals("midrst");
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
